lcd_spi_writer: RTL and testbench

//  Serial back end for the LCD init/clear sequencer. Takes 9-bit words {dc,byte[7:0]} while en_write is high.

---
 rtl/lcd_pkg.sv | 24 ++
 rtl/lcd_spi_writer_if.sv | 12 +
 rtl/lcd_spi_writer_tick.sv | 44 ++++
 rtl/lcd_spi_writer.sv | 117 +++++++++++
 tb/tb_lcd_spi_writer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD SPI writer and its sequencer.
package lcd_pkg;

   localparam int WORD_W         = 9;
   localparam int SCK_DIV_DEF    = 2;
   localparam int SETTLE_CYC_DEF = 2;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_SETTLE = 5'b00010,
      ST_LOAD   = 5'b00100,
      ST_SHIFT  = 5'b01000,
      ST_DONE   = 5'b10000
   } state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lcd_spi_writer_if.sv
// Sequencer-side word handshake of the LCD SPI writer.
interface lcd_spi_writer_if;

   logic                          en_write;
   logic [lcd_pkg::WORD_W-1:0]    init_data;
   logic                          wr_done;
   logic                          busy;

   modport master (output en_write, init_data, input wr_done, busy);
   modport slave  (input en_write, init_data, output wr_done, busy);

endinterface

// File: rtl/lcd_spi_writer_tick.sv
// SCK divider: counts SCK_DIV cycles per half-period and strobes the edge that is due.
module lcd_spi_tick
   import lcd_pkg::*;
#(
   parameter int SCK_DIV = SCK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int            DW   = cnt_w(SCK_DIV);
   localparam logic [DW-1:0] LAST = DW'(SCK_DIV - 1);

   logic [DW-1:0] cnt;
   logic          phase;
   logic          expire;

   // phase tracks the SCK level, so the strobe says which edge comes next
   assign expire    = run && (cnt == LAST);
   assign rise_tick = expire && !phase;
   assign fall_tick = expire && phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (clear) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (run) begin
         if (expire) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_spi_writer.sv
// Serialises {dc,byte} words onto a 4-wire mode-0 SPI panel bus, one wr_done per byte.
// Build option LCD_CS_TOGGLE_EN: drop CS during every SETTLE, giving one CS frame per byte.
module lcd_spi_writer
   import lcd_pkg::*;
#(
   parameter int SCK_DIV    = SCK_DIV_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic            sys_clk_50MHz,
   input  logic            sys_rst_n,
   lcd_spi_writer_if.slave seq,
   output logic            lcd_cs,
   output logic            lcd_dc,
   output logic            lcd_sck,
   output logic            lcd_mosi
);

   localparam int            SW          = cnt_w(SETTLE_CYC + 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC);

   state_t        state, nxt;
   logic [SW-1:0] settle_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          wr_done_q, busy_q;
   logic          rise_tick, fall_tick;
   logic          in_load, in_shift;

   assign in_load     = (state == ST_LOAD);
   assign in_shift    = (state == ST_SHIFT);
   assign seq.wr_done = wr_done_q;
   assign seq.busy    = busy_q;

   lcd_spi_tick #(.SCK_DIV(SCK_DIV)) u_tick (
      .clk       (sys_clk_50MHz),
      .rst_n     (sys_rst_n),
      .clear     (in_load),
      .run       (in_shift),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= ST_IDLE;
      else            state <= nxt;
   end

   // en_write is ignored once a byte is committed in LOAD; only SETTLE may abort
   always_comb begin
      nxt = state;
      unique case (state)
         ST_IDLE:   if (seq.en_write) nxt = ST_SETTLE;
         ST_SETTLE: begin
            if (!seq.en_write)               nxt = ST_IDLE;
            else if (settle_cnt == SETTLE_LAST) nxt = ST_LOAD;
         end
         ST_LOAD:   nxt = ST_SHIFT;
         ST_SHIFT:  if (fall_tick && bit_cnt == 3'd7) nxt = ST_DONE;
         ST_DONE:   nxt = seq.en_write ? ST_SETTLE : ST_IDLE;
         default:   nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         settle_cnt <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
      end else begin
         settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
         if (in_shift && fall_tick) bit_cnt <= bit_cnt + 3'd1;
         if (in_load)
            shreg <= seq.init_data[7:0];
         else if (in_shift && fall_tick)
            shreg <= {shreg[6:0], 1'b0};
      end
   end

   // Pads and handshake are registered off next-state so they line up with the FSM
   always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lcd_cs    <= 1'b1;
         lcd_dc    <= DC_CMD;
         lcd_sck   <= 1'b0;
         lcd_mosi  <= 1'b0;
         wr_done_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         wr_done_q <= (nxt == ST_DONE);
         busy_q    <= (nxt != ST_IDLE);

         if (nxt == ST_LOAD)
            lcd_cs <= 1'b0;
         else if (nxt == ST_IDLE)
            lcd_cs <= 1'b1;
`ifdef LCD_CS_TOGGLE_EN
         else if (state == ST_SETTLE && nxt == ST_SETTLE)
            lcd_cs <= 1'b1;
`endif

         if (in_load) begin
            lcd_dc   <= seq.init_data[WORD_W-1];
            lcd_mosi <= seq.init_data[7];
         end else if (in_shift && fall_tick && bit_cnt != 3'd7) begin
            lcd_mosi <= shreg[6];
         end

         if (nxt != ST_SHIFT)
            lcd_sck <= 1'b0;
         else if (rise_tick)
            lcd_sck <= 1'b1;
         else if (fall_tick)
            lcd_sck <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Scoreboard bench: stimulus queues expected words, a monitor decodes the SPI bus and compares.
module tb_lcd_spi_writer;
   import lcd_pkg::*;

   localparam int SET = 2;
`ifdef LCD_CS_TOGGLE_EN
   localparam int CS_GAP = SET;
`else
   localparam int CS_GAP = 0;
`endif

   typedef struct {
      int         dut;
      logic [8:0] word;
      int         cyc;
      bit         last;
      bit         b2b;
   } exp_t;

   exp_t exp_q[$];

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   bit   fin = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0] en_w;
   logic [8:0] data_w [2];
   logic [1:0] done_w, busy_w, cs_w, dc_w, sck_w, mosi_w;

   lcd_spi_writer_if sif0 ();
   lcd_spi_writer_if sif1 ();

   assign sif0.en_write  = en_w[0];
   assign sif0.init_data = data_w[0];
   assign sif1.en_write  = en_w[1];
   assign sif1.init_data = data_w[1];
   assign done_w = {sif1.wr_done, sif0.wr_done};
   assign busy_w = {sif1.busy, sif0.busy};

   lcd_spi_writer #(.SCK_DIV(2), .SETTLE_CYC(SET)) dut0 (
      .sys_clk_50MHz (clk),
      .sys_rst_n     (rst_n),
      .seq           (sif0),
      .lcd_cs        (cs_w[0]),
      .lcd_dc        (dc_w[0]),
      .lcd_sck       (sck_w[0]),
      .lcd_mosi      (mosi_w[0])
   );

   lcd_spi_writer #(.SCK_DIV(1), .SETTLE_CYC(SET)) dut1 (
      .sys_clk_50MHz (clk),
      .sys_rst_n     (rst_n),
      .seq           (sif1),
      .lcd_cs        (cs_w[1]),
      .lcd_dc        (dc_w[1]),
      .lcd_sck       (sck_w[1]),
      .lcd_mosi      (mosi_w[1])
   );

   function automatic int div_of(input int g);
      return (g == 0) ? 2 : 1;
   endfunction

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   logic [7:0] cap [2];
   int         rises [2];
   int         last_rise [2];
   int         cs_hi [2];
   logic [1:0] psck = '0;
   logic [1:0] dc_cap = '0;
   bit   [1:0] idle_chk = '0;
   bit         prev_rst = 1'b1;

   // Monitor: decodes each DUT's bus every cycle and scores it at wr_done
   initial begin : monitor
      exp_t e;
      for (int g = 0; g < 2; g++) begin
         cap[g] = '0; rises[g] = 0; last_rise[g] = 0; cs_hi[g] = 0;
      end
      forever begin
         @(negedge clk or negedge rst_n or posedge fin);
         #1;
         if (fin) begin
            chk("queue_drained", exp_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
         if (!rst_n) begin
            if (prev_rst)
               for (int g = 0; g < 2; g++)
                  chk("reset_outputs", int'({cs_w[g], dc_w[g], sck_w[g], mosi_w[g],
                                             done_w[g], busy_w[g]}), 32);
            prev_rst = 1'b0;
            for (int g = 0; g < 2; g++) begin
               rises[g] = 0; cs_hi[g] = 0; psck[g] = 1'b0; idle_chk[g] = 1'b0;
            end
         end else begin
            prev_rst = 1'b1;
            for (int g = 0; g < 2; g++) begin
               if (idle_chk[g]) begin
                  chk("idle_after_done", int'({cs_w[g], busy_w[g]}), 2);
                  idle_chk[g] = 1'b0;
               end
               if (sck_w[g] && !psck[g]) begin
                  chk("cs_low_at_rise", int'(cs_w[g]), 0);
                  if (rises[g] > 0) chk("sck_period", cyc - last_rise[g], 2 * div_of(g));
                  else              dc_cap[g] = dc_w[g];
                  cap[g] = {cap[g][6:0], mosi_w[g]};
                  rises[g]++;
                  last_rise[g] = cyc;
               end
               psck[g] = sck_w[g];
               if (cs_w[g]) cs_hi[g]++;
               if (done_w[g]) begin
                  if (exp_q.size() == 0) begin
                     chk("wr_done_expected", exp_q.size(), 1);
                  end else begin
                     e = exp_q.pop_front();
                     chk("dut_index", g, e.dut);
                     chk("byte", int'(cap[g]), int'(e.word[7:0]));
                     chk("dc", int'(dc_cap[g]), int'(e.word[8]));
                     chk("done_cycle", cyc, e.cyc);
                     chk("sck_rises", rises[g], 8);
                     chk("busy_at_done", int'(busy_w[g]), 1);
                     if (e.b2b) chk("cs_high_between", cs_hi[g], CS_GAP);
                     idle_chk[g] = e.last;
                  end
                  rises[g] = 0;
                  cs_hi[g] = 0;
               end
            end
         end
      end
   end

   task automatic wait_done(input int g);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done_w[g]) return;
      end
   endtask

   task automatic start(input int g, input logic [8:0] w, input int lat, input bit last,
                        output int c0);
      @(posedge clk);
      #1;
      c0 = cyc;
      data_w[g] = w;
      en_w[g] = 1'b1;
      exp_q.push_back('{g, w, c0 + lat, last, 1'b0});
   endtask

   initial begin : stimulus
      int c0;
      en_w = '0;
      data_w[0] = '0;
      data_w[1] = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // single command word
      start(0, {DC_CMD, 8'h11}, 37, 1'b1, c0);
      wait_done(0);
      en_w[0] = 1'b0;
      repeat (5) @(posedge clk);

      // two data words back to back
      start(0, {DC_DATA, 8'h60}, 37, 1'b0, c0);
      exp_q.push_back('{0, {DC_DATA, 8'h05}, c0 + 74, 1'b1, 1'b1});
      wait_done(0);
      data_w[0] = {DC_DATA, 8'h05};
      wait_done(0);
      en_w[0] = 1'b0;
      repeat (5) @(posedge clk);

      // en_write and data change mid-SHIFT: byte must still complete intact
      start(0, 9'h02c, 37, 1'b1, c0);
      repeat (10) @(posedge clk);
      #1;
      en_w[0] = 1'b0;
      data_w[0] = 9'h1ff;
      wait_done(0);
      repeat (30) @(posedge clk);

      // reset while bit 3 is on the wire, then a clean byte
      start(0, 9'h0a5, 37, 1'b1, c0);
      repeat (22) @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      data_w[0] = 9'h1c3;
      exp_q.push_back('{0, 9'h1c3, cyc + 37, 1'b1, 1'b0});
      rst_n = 1'b1;
      wait_done(0);
      en_w[0] = 1'b0;
      repeat (5) @(posedge clk);

      // fastest SCK
      start(1, 9'h1ff, 21, 1'b1, c0);
      wait_done(1);
      en_w[1] = 1'b0;
      repeat (5) @(posedge clk);

      // three words back to back
      start(0, 9'h12a, 37, 1'b0, c0);
      exp_q.push_back('{0, 9'h0b4, c0 + 74, 1'b0, 1'b1});
      exp_q.push_back('{0, 9'h1c7, c0 + 111, 1'b1, 1'b1});
      wait_done(0);
      data_w[0] = 9'h0b4;
      wait_done(0);
      data_w[0] = 9'h1c7;
      wait_done(0);
      en_w[0] = 1'b0;
      repeat (10) @(posedge clk);

      fin = 1'b1;
      #1000;
      $display("FAIL summary_not_reached");
      $fatal(1);
   end

endmodule
